sha256_round_engine: RTL and testbench

//  Iterative SHA-256 compression engine that processes one 512-bit chunk per job, given an expanded

---
 rtl/sha256_pkg.sv | 44 ++++
 rtl/sha256_round.sv | 25 ++
 rtl/sha256_round_engine.sv | 85 ++++++++
 tb/tb_sha256_round_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types, round constants and helpers for the round engine
package sha256_pkg;

   localparam int ROUNDS = 64;
   localparam int BYTES_IN_CHUNK = 64;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // state[7]=a ... state[0]=h
   typedef struct packed {
      logic [7:0][31:0] state;
      logic [63:0]      length;
      logic [511:0]     buffer;
      logic [31:0]      curlen;
   } ShaContext;

   // a is the MSB word so a cast to/from ShaContext.state keeps state[7]=a
   typedef struct packed {
      logic [31:0] a, b, c, d, e, f, g, h;
   } Sha256Working;

   localparam logic [0:63][31:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // n must be in 1..31
   function automatic logic [31:0] rightRotate32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [7:0][31:0] sha256_feed_forward(input logic [7:0][31:0] st, input Sha256Working w);
      Sha256Working s;
      s = Sha256Working'(st);
      return {s.a + w.a, s.b + w.b, s.c + w.c, s.d + w.d, s.e + w.e, s.f + w.f, s.g + w.g, s.h + w.h};
   endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round
//  cur  in   working vars a..h before the round
//  w    in   schedule word W[t]
//  k    in   round constant K[t]
//  nxt  out  working vars after the round
module sha256_round
   import sha256_pkg::*;
(
   input  Sha256Working cur,
   input  logic [31:0]  w,
   input  logic [31:0]  k,
   output Sha256Working nxt
);

   logic [31:0] s0, s1, ch, maj, t1, t2;

   assign s1  = rightRotate32(cur.e, 6) ^ rightRotate32(cur.e, 11) ^ rightRotate32(cur.e, 25);
   assign ch  = (cur.e & cur.f) ^ (~cur.e & cur.g);
   assign t1  = cur.h + s1 + ch + k + w;
   assign s0  = rightRotate32(cur.a, 2) ^ rightRotate32(cur.a, 13) ^ rightRotate32(cur.a, 22);
   assign maj = (cur.a & cur.b) ^ (cur.a & cur.c) ^ (cur.b & cur.c);
   assign t2  = s0 + maj;
   assign nxt = {t1 + t2, cur.a, cur.b, cur.c, cur.d + t1, cur.e, cur.f, cur.g};

endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: iterative SHA-256 compression of one chunk per job, ROUNDS_PER_CYCLE rounds/clock
//  clk, rst          clock, synchronous active-high reset
//  in_vld/in_rdy     job handshake carrying in_w (W[0..63]), in_ctx and in_tag
//  out_vld/out_rdy   result handshake carrying out_ctx and out_tag
module sha256_round_engine
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit FEED_FORWARD     = 1,
   parameter int TAG_W            = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_vld,
   output logic                   in_rdy,
   input  logic [63:0][31:0]      in_w,
   input  ShaContext              in_ctx,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output ShaContext              out_ctx,
   output logic [TAG_W-1:0]       out_tag
);

   localparam int R = ROUNDS_PER_CYCLE;
   localparam logic [6:0] LAST = 7'(ROUNDS - R);

   if (!(R inside {1, 2, 4, 8, 16, 32, 64})) begin : g_bad_r
      $error("ROUNDS_PER_CYCLE must be one of 1,2,4,8,16,32,64");
   end

   state_t            st;
   logic [6:0]        rnd;
   logic [63:0][31:0] w_lat;
   ShaContext         ctx_lat;
   logic [TAG_W-1:0]  tag_lat;
   Sha256Working      work;
   Sha256Working      chain [R+1];
   logic [7:0][31:0]  res;
   logic              accept;

   // out_rdy feeds straight through so a DONE result and a new job can swap in one edge
   assign in_rdy  = ~rst & ((st == IDLE) | ((st == DONE) & out_rdy));
   assign out_vld = st == DONE;
   assign accept  = in_vld & in_rdy;

   assign chain[0] = work;
   for (genvar j = 0; j < R; j++) begin : g_rnd
      logic [5:0] idx;
      assign idx = rnd[5:0] + 6'(j);
      sha256_round u_round (.cur(chain[j]), .w(w_lat[idx]), .k(K[idx]), .nxt(chain[j+1]));
   end

   assign res = FEED_FORWARD ? sha256_feed_forward(ctx_lat.state, chain[R]) : chain[R];

   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= IDLE;
         rnd     <= '0;
         out_ctx <= '0;
         out_tag <= '0;
      end else if (accept) begin
         w_lat   <= in_w;
         ctx_lat <= in_ctx;
         tag_lat <= in_tag;
         work    <= Sha256Working'(in_ctx.state);
         rnd     <= '0;
         st      <= RUN;
      end else if (st == RUN) begin
         work <= chain[R];
         rnd  <= rnd + 7'(R);
         if (rnd == LAST) begin
            st             <= DONE;
            out_ctx.state  <= res;
            out_ctx.length <= ctx_lat.length;
            out_ctx.buffer <= ctx_lat.buffer;
            out_ctx.curlen <= ctx_lat.curlen > 32'(BYTES_IN_CHUNK) ? ctx_lat.curlen - 32'(BYTES_IN_CHUNK) : '0;
            out_tag        <= tag_lat;
         end
      end else if (st == DONE && out_rdy) begin
         st <= IDLE;
      end
   end

endmodule

// File: tb/tb_sha256_round_engine.sv
// tb_sha256_round_engine: directed checks of the round engine at R=1/4/64 and with feed-forward off
module tb_sha256_round_engine;
   import sha256_pkg::*;

   localparam logic [7:0][31:0] H0 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [7:0][31:0] DIGEST = {
      32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

   logic              clk = 1'b0;
   logic              rst;
   logic [63:0][31:0] in_w;
   ShaContext         in_ctx;
   logic [3:0]        in_tag;
   logic              vld  [4];
   logic              ordy [4];
   logic              irdy [4];
   logic              ovld [4];
   ShaContext         octx [4];
   logic [3:0]        otag [4];
   logic [63:0][31:0] abc_w;
   int                n_chk = 0;
   int                n_fail = 0;

   always #5 clk = ~clk;

   sha256_round_engine #(.ROUNDS_PER_CYCLE(1), .FEED_FORWARD(1), .TAG_W(4)) u_r1 (
      .clk(clk), .rst(rst), .in_vld(vld[0]), .in_rdy(irdy[0]), .in_w(in_w), .in_ctx(in_ctx), .in_tag(in_tag),
      .out_vld(ovld[0]), .out_rdy(ordy[0]), .out_ctx(octx[0]), .out_tag(otag[0]));
   sha256_round_engine #(.ROUNDS_PER_CYCLE(4), .FEED_FORWARD(1), .TAG_W(4)) u_r4 (
      .clk(clk), .rst(rst), .in_vld(vld[1]), .in_rdy(irdy[1]), .in_w(in_w), .in_ctx(in_ctx), .in_tag(in_tag),
      .out_vld(ovld[1]), .out_rdy(ordy[1]), .out_ctx(octx[1]), .out_tag(otag[1]));
   sha256_round_engine #(.ROUNDS_PER_CYCLE(64), .FEED_FORWARD(1), .TAG_W(4)) u_r64 (
      .clk(clk), .rst(rst), .in_vld(vld[2]), .in_rdy(irdy[2]), .in_w(in_w), .in_ctx(in_ctx), .in_tag(in_tag),
      .out_vld(ovld[2]), .out_rdy(ordy[2]), .out_ctx(octx[2]), .out_tag(otag[2]));
   sha256_round_engine #(.ROUNDS_PER_CYCLE(1), .FEED_FORWARD(0), .TAG_W(4)) u_raw (
      .clk(clk), .rst(rst), .in_vld(vld[3]), .in_rdy(irdy[3]), .in_w(in_w), .in_ctx(in_ctx), .in_tag(in_tag),
      .out_vld(ovld[3]), .out_rdy(ordy[3]), .out_ctx(octx[3]), .out_tag(otag[3]));

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // message schedule of the single padded block for "abc"
   function automatic logic [63:0][31:0] abc_schedule();
      logic [63:0][31:0] w;
      logic [31:0] s0, s1;
      w = '0;
      w[0] = 32'h61626380;
      w[15] = 32'h00000018;
      for (int t = 16; t < 64; t++) begin
         s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      return w;
   endfunction

   task automatic drive_job(input int idx, input logic [3:0] tag, input logic [31:0] curlen,
                            input logic [63:0] len, input logic [511:0] bufv);
      in_w = abc_w;
      in_ctx.state = H0;
      in_ctx.length = len;
      in_ctx.buffer = bufv;
      in_ctx.curlen = curlen;
      in_tag = tag;
      vld[idx] = 1'b1;
   endtask

   task automatic wait_out(input int idx, output int n);
      n = 0;
      while (!ovld[idx] && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vld[i] = 1'b1;
         ordy[i] = 1'b1;
      end
      in_w = '0;
      in_ctx = '0;
      in_tag = 4'hf;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         n_chk += 4;
         if (irdy[i] !== 1'b0) begin n_fail++; $display("FAIL reset in_rdy dut%0d: got %b want 0", i, irdy[i]); end
         if (ovld[i] !== 1'b0) begin n_fail++; $display("FAIL reset out_vld dut%0d: got %b want 0", i, ovld[i]); end
         if (octx[i] !== '0) begin n_fail++; $display("FAIL reset out_ctx dut%0d: not zero", i); end
         if (otag[i] !== 4'h0) begin n_fail++; $display("FAIL reset out_tag dut%0d: got %h want 0", i, otag[i]); end
         vld[i] = 1'b0;
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_abc(input int idx, input int lat, input bit raw, input logic [3:0] tag);
      logic [7:0][31:0] exp_st;
      int n;
      for (int i = 0; i < 8; i++) exp_st[i] = raw ? DIGEST[i] - H0[i] : DIGEST[i];
      drive_job(idx, tag, 32'd0, 64'd24, '0);
      n_chk++;
      if (irdy[idx] !== 1'b1) begin n_fail++; $display("FAIL abc idle in_rdy dut%0d: got %b want 1", idx, irdy[idx]); end
      @(posedge clk);
      #1;
      vld[idx] = 1'b0;
      wait_out(idx, n);
      n_chk += 3;
      if (n != lat) begin n_fail++; $display("FAIL abc latency dut%0d: got %0d want %0d", idx, n, lat); end
      if (octx[idx].state !== exp_st) begin
         n_fail++;
         $display("FAIL abc digest dut%0d: got %h want %h", idx, octx[idx].state, exp_st);
      end
      if (otag[idx] !== tag) begin n_fail++; $display("FAIL abc tag dut%0d: got %h want %h", idx, otag[idx], tag); end
      @(posedge clk);
      #1;
      n_chk++;
      if (ovld[idx] !== 1'b0) begin n_fail++; $display("FAIL abc drain dut%0d: out_vld got %b want 0", idx, ovld[idx]); end
   endtask

   task automatic test_curlen();
      logic [31:0] cl [3] = '{32'd100, 32'd64, 32'd40};
      logic [31:0] ce [3] = '{32'd36, 32'd0, 32'd0};
      logic [63:0] len;
      logic [511:0] bufv;
      int n;
      for (int i = 0; i < 3; i++) begin
         len = 64'h0123456789abcdef ^ 64'(i * 32'h1111);
         bufv = {16{32'hdeadbeef ^ 32'(i)}} ^ {480'd0, 32'h5a5a0000};
         drive_job(2, 4'(i + 8), cl[i], len, bufv);
         @(posedge clk);
         #1;
         vld[2] = 1'b0;
         wait_out(2, n);
         n_chk += 3;
         if (octx[2].curlen !== ce[i]) begin
            n_fail++;
            $display("FAIL curlen in=%0d: got %0d want %0d", cl[i], octx[2].curlen, ce[i]);
         end
         if (octx[2].length !== len) begin n_fail++; $display("FAIL length pass: got %h want %h", octx[2].length, len); end
         if (octx[2].buffer !== bufv) begin n_fail++; $display("FAIL buffer pass: got %h want %h", octx[2].buffer, bufv); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure();
      ShaContext snap;
      logic [3:0] stag;
      int n;
      ordy[2] = 1'b0;
      drive_job(2, 4'h9, 32'd0, 64'd24, '0);
      @(posedge clk);
      #1;
      vld[2] = 1'b0;
      wait_out(2, n);
      snap = octx[2];
      stag = otag[2];
      n_chk += 2;
      if (stag !== 4'h9) begin n_fail++; $display("FAIL stall tag: got %h want 9", stag); end
      if (snap.state !== DIGEST) begin n_fail++; $display("FAIL stall digest: got %h want %h", snap.state, DIGEST); end
      vld[2] = 1'b1;
      in_tag = 4'h7;
      in_ctx.curlen = 32'd123;
      in_ctx.state = '1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if (!(ovld[2] === 1'b1 && octx[2] === snap && otag[2] === stag && irdy[2] === 1'b0)) begin
            n_fail++;
            $display("FAIL stall cycle %0d: out_vld %b in_rdy %b tag %h (want 1 0 %h, ctx held)", c, ovld[2], irdy[2], otag[2], stag);
         end
      end
      vld[2] = 1'b0;
      ordy[2] = 1'b1;
      @(posedge clk);
      #1;
      n_chk += 2;
      if (ovld[2] !== 1'b0) begin n_fail++; $display("FAIL stall release out_vld: got %b want 0", ovld[2]); end
      if (irdy[2] !== 1'b1) begin n_fail++; $display("FAIL stall release in_rdy: got %b want 1", irdy[2]); end
   endtask

   task automatic test_back_to_back();
      drive_job(2, 4'h3, 32'd0, 64'd24, '0);
      @(posedge clk);
      #1;
      in_tag = 4'h5;
      n_chk++;
      if (ovld[2] !== 1'b0 || irdy[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b run: out_vld %b in_rdy %b want 0 0", ovld[2], irdy[2]);
      end
      @(posedge clk);
      #1;
      n_chk += 2;
      if (ovld[2] !== 1'b1 || otag[2] !== 4'h3) begin
         n_fail++;
         $display("FAIL b2b first: out_vld %b tag %h want 1 3", ovld[2], otag[2]);
      end
      if (irdy[2] !== 1'b1) begin n_fail++; $display("FAIL b2b in_rdy in DONE: got %b want 1", irdy[2]); end
      @(posedge clk);
      #1;
      vld[2] = 1'b0;
      n_chk++;
      if (ovld[2] !== 1'b0) begin n_fail++; $display("FAIL b2b second accept: out_vld got %b want 0", ovld[2]); end
      @(posedge clk);
      #1;
      n_chk += 2;
      if (ovld[2] !== 1'b1 || otag[2] !== 4'h5) begin
         n_fail++;
         $display("FAIL b2b second: out_vld %b tag %h want 1 5", ovld[2], otag[2]);
      end
      if (octx[2].state !== DIGEST) begin n_fail++; $display("FAIL b2b digest: got %h want %h", octx[2].state, DIGEST); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      bit seen;
      drive_job(0, 4'hc, 32'd0, 64'd24, '0);
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_chk++;
      if (ovld[0] !== 1'b0) begin n_fail++; $display("FAIL mid reset out_vld: got %b want 0", ovld[0]); end
      seen = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk);
         #1;
         if (ovld[0] !== 1'b0) seen = 1'b1;
      end
      n_chk++;
      if (seen) begin n_fail++; $display("FAIL mid reset partial result: out_vld rose, want stays 0"); end
      test_abc(0, 64, 1'b0, 4'h6);
   endtask

   initial begin
      abc_w = abc_schedule();
      test_reset();
      test_abc(0, 64, 1'b0, 4'h1);
      test_abc(1, 16, 1'b0, 4'h2);
      test_abc(2, 1, 1'b0, 4'h3);
      test_abc(3, 64, 1'b1, 4'h4);
      test_curlen();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
